spi_flash_slave: RTL

- Responder-side SPI flash model that sits on the SPI pads driven by the SoC's APB SPI master bridge, in simulation and in FPGA test builds.
- Decodes the standard READ command: opcode 0x03, then a 24-bit byte address, MSB first.
- Fetches 32-bit words from a backing store over a simple request/response port and shifts them out on MISO, MSB first.
- Supports continuous sequential reads while SS stays asserted, using a one-word prefetch buffer.

---
 rtl/spi_flash_slave.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/spi_flash_slave.sv
// SPI mode-0 flash responder: decodes READ (0x03) plus a 24-bit address and streams
// 32-bit words fetched from a backing store, holding one prefetched word ahead.
module spi_flash_slave #(
  parameter logic [7:0] CMD_READ = 8'h03,
  parameter int         ADDR_W   = 24
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              spi_sck,
  input  logic              spi_ss,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              cmd_err,
  output logic              underrun
);

  localparam logic [5:0] LAST_OP   = 6'd7;
  localparam logic [5:0] LAST_ADDR = 6'(ADDR_W + 7);
  localparam logic [5:0] LAST_BIT  = 6'd31;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_IGNORE} state_t;

  state_t              state, state_nxt;
  logic                sck_q, rise, fall;
  logic [5:0]          cnt;
  logic [ADDR_W-2:0]   in_sr;
  logic [ADDR_W-1:0]   addr_in;
  logic [7:0]          opcode;
  logic [31:0]         out_sr, word_buf;
  logic                buf_valid, pending, discard, req_due;
  logic                op_done, addr_done;

  assign rise      = spi_sck & ~sck_q & ~spi_ss;
  assign fall      = ~spi_sck & sck_q & ~spi_ss;
  assign addr_in   = {in_sr, spi_mosi};
  assign opcode    = addr_in[7:0];
  assign op_done   = (state == S_CMD) && rise && (cnt == LAST_OP);
  assign addr_done = (state == S_ADDR) && rise && (cnt == LAST_ADDR);
  assign busy      = (state != S_IDLE);
  assign spi_miso  = out_sr[31];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (spi_ss) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: state_nxt = S_CMD;
        S_CMD:  if (op_done) state_nxt = (opcode == CMD_READ) ? S_ADDR : S_IGNORE;
        S_ADDR: if (addr_done) state_nxt = S_DATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sck_q     <= 1'b0;
      cnt       <= '0;
      in_sr     <= '0;
      out_sr    <= '0;
      word_buf  <= '0;
      buf_valid <= 1'b0;
      pending   <= 1'b0;
      discard   <= 1'b0;
      req_due   <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      cmd_err   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      sck_q   <= spi_sck;
      mem_req <= 1'b0;
      if (spi_ss) begin
        cnt       <= '0;
        out_sr    <= '0;
        buf_valid <= 1'b0;
        req_due   <= 1'b0;
        // A fetch still in flight belongs to a dead transfer; swallow its response.
        if (mem_rvalid) begin
          pending <= 1'b0;
          discard <= 1'b0;
        end else if (pending) begin
          discard <= 1'b1;
        end
      end else begin
        if (mem_rvalid && pending) begin
          pending <= 1'b0;
          discard <= 1'b0;
          if (!discard && state == S_DATA) begin
            word_buf  <= mem_rdata;
            buf_valid <= 1'b1;
          end
        end
        // First fetch of a transfer waits here if a discarded one is still in flight.
        if (req_due && !pending) begin
          mem_req <= 1'b1;
          pending <= 1'b1;
          req_due <= 1'b0;
        end
        case (state)
          S_IDLE: cnt <= '0;
          S_CMD, S_ADDR: begin
            if (rise) begin
              in_sr <= addr_in[ADDR_W-2:0];
              cnt   <= cnt + 6'd1;
              if (op_done && opcode != CMD_READ) cmd_err <= 1'b1;
              if (addr_done) begin
                cnt       <= '0;
                mem_addr  <= {addr_in[ADDR_W-1:2], 2'b00};
                buf_valid <= 1'b0;
                if (!pending) begin
                  mem_req <= 1'b1;
                  pending <= 1'b1;
                end else begin
                  req_due <= 1'b1;
                end
              end
            end
          end
          S_DATA: begin
            if (fall) begin
              cnt <= (cnt == LAST_BIT) ? 6'd0 : cnt + 6'd1;
              if (cnt == 6'd0) begin
                if (buf_valid) begin
                  out_sr    <= word_buf;
                  buf_valid <= 1'b0;
                  if (!pending && !req_due) begin
                    mem_addr <= mem_addr + ADDR_W'(4);
                    mem_req  <= 1'b1;
                    pending  <= 1'b1;
                  end
                end else begin
                  out_sr   <= '0;
                  underrun <= 1'b1;
                end
              end else begin
                out_sr <= {out_sr[30:0], 1'b0};
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
